// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one FP multiplier among NUM_REQ requesters.
// Operands are buffered per requester; one multiplication is outstanding at a time.
module mul_share_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NUM_REQ-1:0]      req_trig,
    input  logic [32*NUM_REQ-1:0]   req_data1,
    input  logic [32*NUM_REQ-1:0]   req_data2,
    output logic [31:0]             req_result,
    output logic [NUM_REQ-1:0]      req_vld,
    output logic [NUM_REQ-1:0]      req_err,
    output logic                    busy,
    output logic [31:0]             mul_data1_out,
    output logic [31:0]             mul_data2_out,
    output logic                    mul_trig_out,
    input  logic [31:0]             mul_result_in,
    input  logic                    mul_result_vld
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               stateQ, stateD;
    logic [NUM_REQ-1:0]   pendingQ, pendingD;
    logic [31:0]          opAQ [NUM_REQ];
    logic [31:0]          opAD [NUM_REQ];
    logic [31:0]          opBQ [NUM_REQ];
    logic [31:0]          opBD [NUM_REQ];
    logic [IW-1:0]        lastQ, lastD;
    logic [IW-1:0]        grantQ, grantD;
    logic [31:0]          cntQ, cntD;
    logic [31:0]          resultQ, resultD;
    logic [NUM_REQ-1:0]   vldQ, vldD;
    logic [NUM_REQ-1:0]   errQ, errD;
    logic [31:0]          mulAQ, mulAD;
    logic [31:0]          mulBQ, mulBD;
    logic                 mulTrigQ, mulTrigD;

    logic                 pickValid;
    logic [IW-1:0]        pickIdx;
    logic [IW-1:0]        cand;
    logic [NUM_REQ-1:0]   clrMask;

    // Search pending requesters starting just after the last grant.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = lastQ;
        cand      = lastQ;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(lastQ) + k) % NUM_REQ);
            if (!pickValid && pendingQ[cand]) begin
                pickValid = 1'b1;
                pickIdx   = cand;
            end
        end
    end

    always_comb begin
        stateD   = stateQ;
        lastD    = lastQ;
        grantD   = grantQ;
        cntD     = cntQ;
        resultD  = resultQ;
        vldD     = '0;
        errD     = '0;
        mulAD    = mulAQ;
        mulBD    = mulBQ;
        mulTrigD = 1'b0;
        clrMask  = '0;
        opAD     = opAQ;
        opBD     = opBQ;

        case (stateQ)
            IDLE: begin
                if (pickValid) begin
                    grantD   = pickIdx;
                    lastD    = pickIdx;
                    mulAD    = opAQ[pickIdx];
                    mulBD    = opBQ[pickIdx];
                    mulTrigD = 1'b1;
                    cntD     = '0;
                    stateD   = WAIT;
                end
            end
            WAIT: begin
                if (mul_result_vld) begin
                    resultD          = mul_result_in;
                    vldD[grantQ]     = 1'b1;
                    clrMask[grantQ]  = 1'b1;
                    stateD           = IDLE;
                end else if ((TIMEOUT != 0) && (cntQ == 32'(TIMEOUT - 1))) begin
                    resultD          = 32'h7FC0_0000;
                    errD[grantQ]     = 1'b1;
                    clrMask[grantQ]  = 1'b1;
                    stateD           = IDLE;
                end else if (!mulTrigQ) begin
                    // The issue cycle itself does not consume watchdog budget.
                    cntD = cntQ + 32'd1;
                end
            end
            default: stateD = IDLE;
        endcase

        // A trigger landing on the clearing cycle is accepted (set wins).
        pendingD = pendingQ & ~clrMask;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_trig[i] && (!pendingQ[i] || clrMask[i])) begin
                pendingD[i] = 1'b1;
                opAD[i]     = req_data1[32*i +: 32];
                opBD[i]     = req_data2[32*i +: 32];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stateQ   <= IDLE;
            pendingQ <= '0;
            lastQ    <= IW'(NUM_REQ - 1);
            grantQ   <= '0;
            cntQ     <= '0;
            resultQ  <= '0;
            vldQ     <= '0;
            errQ     <= '0;
            mulAQ    <= '0;
            mulBQ    <= '0;
            mulTrigQ <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                opAQ[i] <= '0;
                opBQ[i] <= '0;
            end
        end else begin
            stateQ   <= stateD;
            pendingQ <= pendingD;
            lastQ    <= lastD;
            grantQ   <= grantD;
            cntQ     <= cntD;
            resultQ  <= resultD;
            vldQ     <= vldD;
            errQ     <= errD;
            mulAQ    <= mulAD;
            mulBQ    <= mulBD;
            mulTrigQ <= mulTrigD;
            for (int i = 0; i < NUM_REQ; i++) begin
                opAQ[i] <= opAD[i];
                opBQ[i] <= opBD[i];
            end
        end
    end

    assign req_result    = resultQ;
    assign req_vld       = vldQ;
    assign req_err       = errQ;
    assign busy          = (stateQ == WAIT);
    assign mul_data1_out = mulAQ;
    assign mul_data2_out = mulBQ;
    assign mul_trig_out  = mulTrigQ;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a small fixed-latency multiplier stand-in.
module tb_mul_share_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [N-1:0]     req_trig = '0;
    logic [32*N-1:0]  req_data1 = '0;
    logic [32*N-1:0]  req_data2 = '0;
    logic [31:0]      req_result;
    logic [N-1:0]     req_vld;
    logic [N-1:0]     req_err;
    logic             busy;
    logic [31:0]      mul_data1_out;
    logic [31:0]      mul_data2_out;
    logic             mul_trig_out;
    logic [31:0]      mul_result_in = '0;
    logic             mul_result_vld = 1'b0;

    int               testsRun = 0;
    int               testsFailed = 0;
    int               mulCount = 0;
    int               mulLat = 4;
    bit               mulEnable = 1'b1;
    logic [31:0]      mulA = '0;
    logic [31:0]      mulB = '0;

    mul_share_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .req_trig       (req_trig),
        .req_data1      (req_data1),
        .req_data2      (req_data2),
        .req_result     (req_result),
        .req_vld        (req_vld),
        .req_err        (req_err),
        .busy           (busy),
        .mul_data1_out  (mul_data1_out),
        .mul_data2_out  (mul_data2_out),
        .mul_trig_out   (mul_trig_out),
        .mul_result_in  (mul_result_in),
        .mul_result_vld (mul_result_vld)
    );

    always #5 sys_clk = ~sys_clk;

    // Known products for the operand pairs used below.
    function automatic logic [31:0] mulModel(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F80_0000, 32'h4000_0000}: return 32'h4000_0000;
            {32'h4040_0000, 32'h4000_0000}: return 32'h40C0_0000;
            {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
            default:                        return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Advance to the next falling edge, end trigger pulses and run the multiplier stand-in.
    task automatic tick();
        @(negedge sys_clk);
        req_trig       = '0;
        mul_result_vld = 1'b0;
        if (mulCount > 0) begin
            mulCount--;
            if (mulCount == 0) begin
                mul_result_in  = mulModel(mulA, mulB);
                mul_result_vld = 1'b1;
            end
        end
        if (mulEnable && mul_trig_out === 1'b1) begin
            mulA     = mul_data1_out;
            mulB     = mul_data2_out;
            mulCount = mulLat;
        end
    endtask

    task automatic setOps(input int i, input logic [31:0] a, input logic [31:0] b);
        req_data1[32*i +: 32] = a;
        req_data2[32*i +: 32] = b;
    endtask

    task automatic doReset();
        sys_rst_n      = 1'b0;
        req_trig       = '0;
        mul_result_vld = 1'b0;
        mulCount       = 0;
        mulEnable      = 1'b1;
        mulLat         = 4;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic waitTrig(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (mul_trig_out !== 1'b1 && n < 30);
        if (mul_trig_out !== 1'b1) n = -1;
    endtask

    task automatic waitDone(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (req_vld === '0 && req_err === '0 && n < 40);
        if (req_vld === '0 && req_err === '0) n = -1;
    endtask

    task automatic test_reset();
        #1;
        testsRun++; if (req_result !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_result: got %h expected 00000000", req_result); end
        testsRun++; if (req_vld !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_vld: got %b expected 000", req_vld); end
        testsRun++; if (req_err !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_err: got %b expected 000", req_err); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        testsRun++; if (mul_data1_out !== 32'h0 || mul_data2_out !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_muldata: got %h/%h expected 0/0", mul_data1_out, mul_data2_out); end
        testsRun++; if (mul_trig_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_trig: got %b expected 0", mul_trig_out); end
    endtask

    task automatic test_single();
        int n;
        doReset();
        setOps(0, 32'h3F80_0000, 32'h4000_0000);
        req_trig = 3'b001;
        waitTrig(n);
        testsRun++; if (n !== 2) begin testsFailed++; $display("[TB] FAIL single_issue_latency: got %0d expected 2", n); end
        testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        testsRun++; if (mul_data1_out !== 32'h3F80_0000 || mul_data2_out !== 32'h4000_0000) begin testsFailed++; $display("[TB] FAIL single_operands: got %h/%h expected 3f800000/40000000", mul_data1_out, mul_data2_out); end
        waitDone(n);
        testsRun++; if (n !== 5) begin testsFailed++; $display("[TB] FAIL single_done_latency: got %0d expected 5", n); end
        testsRun++; if (req_vld !== 3'b001 || req_err !== 3'b000) begin testsFailed++; $display("[TB] FAIL single_vld: got %b/%b expected 001/000", req_vld, req_err); end
        testsRun++; if (req_result !== 32'h4000_0000) begin testsFailed++; $display("[TB] FAIL single_result: got %h expected 40000000", req_result); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_idle: got %b expected 0", busy); end
        tick();
        testsRun++; if (req_vld !== 3'b000 || mul_trig_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_pulse_end: got %b/%b expected 000/0", req_vld, mul_trig_out); end
    endtask

    task automatic test_simultaneous();
        int n;
        logic [2:0]  expVld [3];
        logic [31:0] expRes [3];
        expVld = '{3'b001, 3'b010, 3'b100};
        expRes = '{32'h4000_0000, 32'h40C0_0000, 32'h4080_0000};
        doReset();
        setOps(0, 32'h3F80_0000, 32'h4000_0000);
        setOps(1, 32'h4040_0000, 32'h4000_0000);
        setOps(2, 32'h4000_0000, 32'h4000_0000);
        req_trig = 3'b111;
        for (int j = 0; j < 3; j++) begin
            waitDone(n);
            testsRun++; if (req_vld !== expVld[j]) begin testsFailed++; $display("[TB] FAIL simul_grant%0d: got %b expected %b", j, req_vld, expVld[j]); end
            testsRun++; if (req_result !== expRes[j]) begin testsFailed++; $display("[TB] FAIL simul_result%0d: got %h expected %h", j, req_result, expRes[j]); end
            if (j > 0) begin
                testsRun++; if (n !== 6) begin testsFailed++; $display("[TB] FAIL simul_gap%0d: got %0d expected 6", j, n); end
            end
        end
    endtask

    task automatic test_fairness();
        int n;
        logic [2:0] expVld [4];
        expVld = '{3'b001, 3'b100, 3'b001, 3'b100};
        doReset();
        setOps(0, 32'h3F80_0000, 32'h4000_0000);
        setOps(2, 32'h4000_0000, 32'h4000_0000);
        req_trig = 3'b101;
        for (int j = 0; j < 4; j++) begin
            waitDone(n);
            testsRun++; if (req_vld !== expVld[j]) begin testsFailed++; $display("[TB] FAIL fair_grant%0d: got %b expected %b", j, req_vld, expVld[j]); end
            req_trig = req_vld;
        end
    endtask

    task automatic test_set_wins();
        int n;
        doReset();
        setOps(1, 32'h4040_0000, 32'h4000_0000);
        req_trig = 3'b010;
        n = 0;
        do begin
            tick();
            n++;
        end while (mul_result_vld !== 1'b1 && n < 30);
        setOps(1, 32'h4000_0000, 32'h4000_0000);
        req_trig = 3'b010;
        waitDone(n);
        testsRun++; if (req_vld !== 3'b010 || req_result !== 32'h40C0_0000) begin testsFailed++; $display("[TB] FAIL setwins_first: got %b/%h expected 010/40c00000", req_vld, req_result); end
        waitDone(n);
        testsRun++; if (req_vld !== 3'b010 || req_result !== 32'h4080_0000) begin testsFailed++; $display("[TB] FAIL setwins_second: got %b/%h expected 010/40800000", req_vld, req_result); end
    endtask

    task automatic test_drop();
        int n;
        int extra;
        doReset();
        setOps(1, 32'h4040_0000, 32'h4000_0000);
        req_trig = 3'b010;
        tick();
        setOps(1, 32'h3F80_0000, 32'h3F80_0000);
        req_trig = 3'b010;
        waitTrig(n);
        testsRun++; if (mul_data1_out !== 32'h4040_0000 || mul_data2_out !== 32'h4000_0000) begin testsFailed++; $display("[TB] FAIL drop_operands: got %h/%h expected 40400000/40000000", mul_data1_out, mul_data2_out); end
        waitDone(n);
        testsRun++; if (req_vld !== 3'b010 || req_result !== 32'h40C0_0000) begin testsFailed++; $display("[TB] FAIL drop_result: got %b/%h expected 010/40c00000", req_vld, req_result); end
        extra = 0;
        repeat (15) begin
            tick();
            if (req_vld !== 3'b000 || mul_trig_out !== 1'b0) extra++;
        end
        testsRun++; if (extra !== 0) begin testsFailed++; $display("[TB] FAIL drop_extra: got %0d expected 0", extra); end
    endtask

    task automatic test_timeout();
        int n;
        doReset();
        mulEnable = 1'b0;
        setOps(2, 32'h4000_0000, 32'h4000_0000);
        req_trig = 3'b100;
        waitTrig(n);
        setOps(0, 32'h3F80_0000, 32'h4000_0000);
        req_trig = 3'b001;
        waitDone(n);
        testsRun++; if (n !== TO + 1) begin testsFailed++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", n, TO + 1); end
        testsRun++; if (req_err !== 3'b100 || req_vld !== 3'b000) begin testsFailed++; $display("[TB] FAIL timeout_err: got %b/%b expected 100/000", req_err, req_vld); end
        testsRun++; if (req_result !== 32'h7FC0_0000) begin testsFailed++; $display("[TB] FAIL timeout_nan: got %h expected 7fc00000", req_result); end
        mul_result_in  = 32'h1234_5678;
        mul_result_vld = 1'b1;
        mulEnable      = 1'b1;
        tick();
        testsRun++; if (req_vld !== 3'b000 || req_err !== 3'b000 || req_result !== 32'h7FC0_0000) begin testsFailed++; $display("[TB] FAIL timeout_stale: got %b/%b/%h expected 000/000/7fc00000", req_vld, req_err, req_result); end
        testsRun++; if (mul_trig_out !== 1'b1 || mul_data1_out !== 32'h3F80_0000) begin testsFailed++; $display("[TB] FAIL timeout_next_issue: got %b/%h expected 1/3f800000", mul_trig_out, mul_data1_out); end
        waitDone(n);
        testsRun++; if (req_vld !== 3'b001 || req_result !== 32'h4000_0000) begin testsFailed++; $display("[TB] FAIL timeout_next_done: got %b/%h expected 001/40000000", req_vld, req_result); end
    endtask

    task automatic test_valid_wins();
        int n;
        doReset();
        mulLat = TO;
        setOps(0, 32'h3F80_0000, 32'h4000_0000);
        req_trig = 3'b001;
        waitTrig(n);
        waitDone(n);
        testsRun++; if (n !== TO + 1) begin testsFailed++; $display("[TB] FAIL vwins_latency: got %0d expected %0d", n, TO + 1); end
        testsRun++; if (req_vld !== 3'b001 || req_err !== 3'b000 || req_result !== 32'h4000_0000) begin testsFailed++; $display("[TB] FAIL vwins_result: got %b/%b/%h expected 001/000/40000000", req_vld, req_err, req_result); end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int extra;
        doReset();
        setOps(1, 32'h4040_0000, 32'h4000_0000);
        req_trig = 3'b010;
        waitTrig(n);
        tick();
        tick();
        testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstwait_in_wait: got %b expected 1", busy); end
        sys_rst_n = 1'b0;
        #1;
        testsRun++; if (busy !== 1'b0 || mul_trig_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstwait_busy: got %b/%b expected 0/0", busy, mul_trig_out); end
        testsRun++; if (mul_data1_out !== 32'h0 || mul_data2_out !== 32'h0 || req_result !== 32'h0) begin testsFailed++; $display("[TB] FAIL rstwait_data: got %h/%h/%h expected 0/0/0", mul_data1_out, mul_data2_out, req_result); end
        tick();
        tick();
        sys_rst_n = 1'b1;
        extra = 0;
        repeat (10) begin
            tick();
            if (req_vld !== 3'b000 || req_err !== 3'b000 || mul_trig_out !== 1'b0) extra++;
        end
        testsRun++; if (extra !== 0) begin testsFailed++; $display("[TB] FAIL rstwait_no_output: got %0d expected 0", extra); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_set_wins();
        test_drop();
        test_timeout();
        test_valid_wins();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that time-shares the single IEEE-754 single-precision multiplier (MultiUnit) of the ALU among `NUM_REQ` requesters, e.g. the top-level multiply op, the divider's Newton-Raphson iterations and square root. It buffers each requester's operands on a trigger pulse and issues one multiplication at a time. It waits for the multiplier's valid strobe and routes the result back with a one-hot valid pulse. A watchdog aborts an operation the multiplier never completes.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, at least 2.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before abort. 0 disables the watchdog.

Ports:
- `sys_clk`  in  1  clock. Reset `sys_rst_n` is asynchronous and active-low; clock is `sys_clk`.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `req_trig`  in  `NUM_REQ`  per-requester single-cycle request pulse.
- `req_data1`  in  32·`NUM_REQ`  operand A. Requester i uses slice [32i+31:32i].
- `req_data2`  in  32·`NUM_REQ`  operand B, sliced the same way.
- `req_result`  out  32  shared result bus, valid while any `req_vld`/`req_err` bit is high.
- `req_vld`  out  `NUM_REQ`  one-hot single-cycle completion pulse.
- `req_err`  out  `NUM_REQ`  one-hot single-cycle timeout pulse.
- `busy`  out  1  high in WAIT.
- `mul_data1_out`  out  32  operand A to the multiplier.
- `mul_data2_out`  out  32  operand B to the multiplier.
- `mul_trig_out`  out  1  single-cycle start pulse to the multiplier.
- `mul_result_in`  in  32  multiplier product.
- `mul_result_vld`  in  1  single-cycle product-valid strobe.

## Operation
- Per-requester buffer: a `pending[i]` flag plus two 32-bit operand registers.
- `req_trig[i]` with `pending[i]`=0: capture both operand slices and set `pending[i]`.
- `req_trig[i]` with `pending[i]`=1: the pulse is dropped and the stored operands are unchanged.
- A `req_trig[i]` arriving in the same cycle that `pending[i]` clears is accepted: set wins.
- Round-robin: pointer `last` holds the most recently granted index; reset value is `NUM_REQ`-1. Search order is `last`+1, `last`+2, … modulo `NUM_REQ`; the first pending index wins.
- FSM states: IDLE, WAIT.
  - IDLE with any pending bit set: register `grant`, load `mul_data1_out`/`mul_data2_out` from that requester's buffer, pulse `mul_trig_out` (registered), update `last`=`grant`, clear the watchdog counter, go to WAIT.
  - IDLE with no pending bits: stay in IDLE.
  - WAIT with `mul_result_vld`=1: register `req_result`=`mul_result_in`, pulse `req_vld[grant]`, clear `pending[grant]`, go to IDLE.
  - WAIT with counter = `TIMEOUT`-1 and no valid strobe (`TIMEOUT`≠0): `req_result`=32'h7FC00000 (quiet NaN), pulse `req_err[grant]`, clear `pending[grant]`, go to IDLE.
  - WAIT otherwise: counter increments.
- `mul_result_vld` in IDLE is ignored, including a stale strobe that arrives after a timeout or after reset.
- `mul_data*_out` and `req_result` hold their last value. Only the pulse outputs return to 0.
- Only one multiplication is outstanding at a time.
- No arithmetic is performed on operands; they are passed through bit-exact.

## Timing
- Reset value of every output is 0: `req_result`, `req_vld`, `req_err`, `busy`, `mul_data1_out`, `mul_data2_out`, `mul_trig_out`.
- Reset also clears `pending` and the operand buffers, sets state to IDLE, sets the counter to 0 and sets `last` to `NUM_REQ`-1.
- Reset mid-WAIT abandons the operation; no `req_vld`/`req_err` is produced.
- Request latency: `req_trig` sampled at edge E → `pending` set after E → `mul_trig_out` high in the cycle after E+1 (two cycles trig→issue, arbiter idle).
- `busy` rises in the same cycle as `mul_trig_out`. WAIT includes that cycle, so the counter reads 0 there.
- Completion: `mul_result_vld` high in cycle R → `req_vld`/`req_result` high in R+1, with state IDLE in R+1.
- Next issue: `mul_trig_out` in R+2 at the earliest; back-to-back throughput is multiplier latency + 2 cycles.
- Timeout: `req_err` is asserted exactly `TIMEOUT`+1 cycles after `mul_trig_out` when no valid strobe arrives.
- `mul_result_vld` arriving in the final timeout cycle counts as a completion: valid wins over timeout.
- `mul_trig_out`, `req_vld` and `req_err` are never high for two consecutive cycles.

## Test plan
- Single request: `req_trig[0]` with A=3F800000 (1.0), B=40000000 (2.0); model multiplier returns 40000000 after 4 cycles → `mul_trig_out` two cycles after trig, then `req_vld`=001 and `req_result`=40000000 one cycle after the strobe.
- Simultaneous requests: trig all three in one cycle with distinct operands → grants in order 0,1,2, with one `req_vld` per requester carrying its own product (e.g. 3.0×2.0=40C00000 for requester 1).
- Fairness: requester 0 retriggers immediately after each completion while requester 2 is pending → grants alternate 0,2,0,2 and requester 2 is never starved.
- Drop rule: second `req_trig[1]` with different operands while `pending[1]` is set → the originally captured operands are issued and there is exactly one `req_vld[1]`.
- Timeout: with `TIMEOUT`=8, the multiplier never responds → `req_err[grant]` 9 cycles after `mul_trig_out` with `req_result`=7FC00000; a late strobe is ignored and the next pending request issues normally.
- Reset mid-WAIT: assert `sys_rst_n`=0 during WAIT → all outputs 0 immediately; after release, no `req_vld` appears even if `mul_result_vld` pulses.
